// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module   : icache
//  Desc     : Direct-mapped, one-word-per-line instruction cache. Same-cycle
//             hit path to the fetcher; single outstanding refill to the
//             memory controller on a miss. Optional flush support is compiled
//             in with the ICACHE_FLUSH_EN macro.
//  Revision : 1.0 - initial release
// ============================================================================
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        instr_2if_valid,
    output logic [31:0] instr_2if,
    output logic        req_2mc,
    output logic [31:0] addr_2mc,
    input  logic        mc_valid,
`ifdef ICACHE_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [31:0] mc_data
);

    localparam int c_LINES    = 1 << INDEX_BITS;
    localparam int c_TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [31:2]             r_miss_word;
    logic [c_LINES-1:0]      r_valid;
    logic [c_TAG_BITS-1:0]   r_tag  [c_LINES];
    logic [31:0]             r_data [c_LINES];

    logic [INDEX_BITS-1:0]   w_idx;
    logic [c_TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0]   w_fill_idx;
    logic [c_TAG_BITS-1:0]   w_fill_tag;
    logic                    w_lookup;
    logic                    w_hit;
    logic                    w_miss_start;
    logic                    w_fill_done;
    logic                    w_fill_we;
    logic                    w_inval;
    logic                    w_unused;

    assign w_idx      = fetch_pc[INDEX_BITS+1:2];
    assign w_tag      = fetch_pc[31:INDEX_BITS+2];
    assign w_fill_idx = r_miss_word[INDEX_BITS+1:2];
    assign w_fill_tag = r_miss_word[31:INDEX_BITS+2];
    assign w_unused   = ^fetch_pc[1:0];

    // A lookup only counts as a hit when the FSM is idle and the pipe is live
    assign w_lookup = fetch_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag)
                    & (r_state == S_IDLE) & rdy;

`ifdef ICACHE_FLUSH_EN
    logic r_drop_fill;

    // A flush is only honoured while the pipe is running
    assign w_inval   = flush & rdy;
    // Fills requested before a flush are stale and must not land in the array
    assign w_fill_we = w_fill_done & ~r_drop_fill & ~w_inval;

    // Remember that the outstanding refill was overtaken by a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_fill <= 1'b0;
        end else if (rdy) begin
            if (w_fill_done) begin
                r_drop_fill <= 1'b0;
            end else if (w_inval && (r_state == S_MISS)) begin
                r_drop_fill <= 1'b1;
            end
        end
    end
`else
    assign w_inval   = 1'b0;
    assign w_fill_we = w_fill_done;
`endif

    assign w_hit           = w_lookup & ~w_inval;
    assign instr_2if_valid = w_hit;
    assign instr_2if       = r_data[w_idx];
    assign req_2mc         = (r_state == S_MISS);
    assign addr_2mc        = {r_miss_word, 2'b00};

    // Next-state logic: launch a refill on a miss, return on the refill beat
    always_comb begin
        w_state_nxt  = r_state;
        w_miss_start = 1'b0;
        w_fill_done  = 1'b0;
        if (rdy) begin
            case (r_state)
                S_IDLE: begin
                    if (fetch_req && !w_hit) begin
                        w_state_nxt  = S_MISS;
                        w_miss_start = 1'b1;
                    end
                end
                S_MISS: begin
                    if (mc_valid) begin
                        w_state_nxt = S_IDLE;
                        w_fill_done = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register and latched miss address (drive the refill request)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_miss_word <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_miss_start) begin
                r_miss_word <= fetch_pc[31:2];
            end
        end
    end

    // Valid bits: cleared by reset or flush, set when a refill is installed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_inval) begin
            r_valid <= '0;
        end else if (w_fill_we) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: written only by an accepted refill
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= mc_data;
        end
    end

endmodule
`default_nettype wire
